nand_ecc_correct: RTL and testbench

Read-path ECC checker and corrector for the NAND flash controller. It sits beside the existing Hamming ECC generator. After a 512-byte sector has been read from flash into the dual-port page RAM and its 24-bit ECC recomputed, this block compares the recomputed ECC with the ECC stored in the spare area and classifies the result. If a single-bit data error is found, it performs a read-modify-write on the page RAM (port A) to flip the bad bit. It then reports status to the PPC-side register interface.

---
 rtl/nand_ecc_correct.sv | 132 +++++++++++++
 tb/tb_nand_ecc_correct.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nand_ecc_correct.sv
// Read-path ECC checker/corrector: classifies the stored^calc syndrome and flips a single bad data bit in page RAM.
// Latency: done 2 cycles after start (clean/ECC-field/uncorrectable), 5 cycles when a read-modify-write correction runs.
// Backpressure: none; start is only sampled in IDLE and ignored while busy.
module nand_ecc_correct #(
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [23:0]       stored_ecc,
    input  logic [23:0]       calc_ecc,
    input  logic [ADDR_W-1:0] base_addr,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [31:0]       ram_rdata,
    output logic [31:0]       ram_wdata,
    output logic              ram_we,
    output logic              busy,
    output logic              done,
    output logic [1:0]        err_status,
    output logic [8:0]        err_byte,
    output logic [2:0]        err_bit
);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        READ,
        WAIT,
        WRITE,
        DONE
    } state_t;

    state_t            state;
    logic [23:0]       syn;
    logic [ADDR_W-1:0] base;

    logic [11:0]       loc;
    logic [11:0]       pair_x;
    logic [1:0]        cls;
    logic [ADDR_W-1:0] target;
    logic [4:0]        bit_pos;
    logic [31:0]       flip_mask;

    // loc gathers the P_k bits; a single data-bit error makes every P_k/P_k' pair disagree.
    always_comb begin
        loc    = '0;
        pair_x = '0;
        for (int k = 0; k < 12; k++) begin
            loc[k]    = syn[2*k+1];
            pair_x[k] = syn[2*k+1] ^ syn[2*k];
        end
    end

    always_comb begin
        if (syn == 24'd0)
            cls = 2'd0;
        else if (&pair_x)
            cls = 2'd1;
        else if ($countones(syn) == 1)
            cls = 2'd2;
        else
            cls = 2'd3;
    end

    assign target    = base + ADDR_W'(loc[11:5]);
    assign bit_pos   = {err_byte[1:0], err_bit};
    assign flip_mask = 32'h1 << bit_pos;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            syn        <= '0;
            base       <= '0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            ram_we     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err_status <= 2'd0;
            err_byte   <= '0;
            err_bit    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        syn   <= stored_ecc ^ calc_ecc;
                        base  <= base_addr;
                        busy  <= 1'b1;
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    err_status <= cls;
                    if (cls == 2'd1) begin
                        err_byte <= loc[11:3];
                        err_bit  <= loc[2:0];
                        ram_addr <= target;
                        state    <= READ;
                    end else begin
                        err_byte <= '0;
                        err_bit  <= '0;
                        done     <= 1'b1;
                        state    <= DONE;
                    end
                end
                READ: begin
                    state <= WAIT;
                end
                WAIT: begin
                    ram_wdata <= ram_rdata ^ flip_mask;
                    ram_we    <= 1'b1;
                    state     <= WRITE;
                end
                WRITE: begin
                    ram_we <= 1'b0;
                    done   <= 1'b1;
                    state  <= DONE;
                end
                DONE: begin
                    done     <= 1'b0;
                    busy     <= 1'b0;
                    ram_addr <= '0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nand_ecc_correct.sv
// Scoreboard bench for nand_ecc_correct: driver pushes expected completions/writes, monitor pops and compares.
module tb_nand_ecc_correct;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [23:0] stored_ecc = '0;
    logic [23:0] calc_ecc = '0;
    logic [8:0]  base_addr = '0;
    logic [8:0]  ram_addr;
    logic [31:0] ram_rdata;
    logic [31:0] ram_wdata;
    logic        ram_we;
    logic        busy;
    logic        done;
    logic [1:0]  err_status;
    logic [8:0]  err_byte;
    logic [2:0]  err_bit;

    nand_ecc_correct #(.ADDR_W(9)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stored_ecc (stored_ecc),
        .calc_ecc   (calc_ecc),
        .base_addr  (base_addr),
        .ram_addr   (ram_addr),
        .ram_rdata  (ram_rdata),
        .ram_wdata  (ram_wdata),
        .ram_we     (ram_we),
        .busy       (busy),
        .done       (done),
        .err_status (err_status),
        .err_byte   (err_byte),
        .err_bit    (err_bit)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Page RAM port A: synchronous read, one-cycle latency.
    logic [31:0] mem [512];
    always @(posedge clk) begin
        ram_rdata <= mem[ram_addr];
        if (ram_we) mem[ram_addr] <= ram_wdata;
    end

    typedef struct {
        int st;
        int byt;
        int bt;
        int sc;
        int lat;
    } exp_t;

    typedef struct {
        logic [8:0]  addr;
        logic [31:0] data;
        int          sc;
    } wr_t;

    exp_t exp_q[$];
    wr_t  wr_q[$];

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference classification straight from the pair rules of the ECC layout.
    function automatic void classify(input logic [23:0] s, output int st, output int byt, output int bt);
        int loc = 0;
        bit all_pairs = 1'b1;
        for (int k = 0; k < 12; k++) begin
            if (s[2*k+1] == s[2*k]) all_pairs = 1'b0;
            if (s[2*k+1]) loc = loc + (1 << k);
        end
        if (s == 24'd0)                st = 0;
        else if (all_pairs)            st = 1;
        else if ($countones(s) == 1)   st = 2;
        else                           st = 3;
        byt = (st == 1) ? loc / 8 : 0;
        bt  = (st == 1) ? loc % 8 : 0;
    endfunction

    function automatic logic [23:0] encode_err(input int byt, input int bt);
        logic [23:0] s = '0;
        int loc = byt * 8 + bt;
        for (int k = 0; k < 12; k++) begin
            if ((loc >> k) & 1) s[2*k+1] = 1'b1;
            else                s[2*k]   = 1'b1;
        end
        return s;
    endfunction

    task automatic push_exp(input int sc);
        exp_t e;
        wr_t  w;
        classify(stored_ecc ^ calc_ecc, e.st, e.byt, e.bt);
        e.sc  = sc;
        e.lat = (e.st == 1) ? 5 : 2;
        exp_q.push_back(e);
        if (e.st == 1) begin
            w.addr = 9'(int'(base_addr) + e.byt / 4);
            w.data = mem[w.addr] ^ (32'h1 << (8 * (e.byt % 4) + e.bt));
            w.sc   = sc;
            wr_q.push_back(w);
        end
    endtask

    exp_t me;
    wr_t  mw;
    always @(negedge clk) begin
        if (ram_we) begin
            if (wr_q.size() == 0) begin
                chk("unexpected_we", {55'd0, ram_addr}, 64'h1FF_FFFF);
            end else begin
                mw = wr_q.pop_front();
                chk("we_addr", {55'd0, ram_addr}, {55'd0, mw.addr});
                chk("we_data", {32'd0, ram_wdata}, {32'd0, mw.data});
                chk("we_cycle", 64'(cyc - mw.sc), 64'd4);
            end
        end
        if (done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", {63'd0, done}, 64'd0);
            end else begin
                me = exp_q.pop_front();
                chk("err_status", {62'd0, err_status}, 64'(me.st));
                chk("err_byte", {55'd0, err_byte}, 64'(me.byt));
                chk("err_bit", {61'd0, err_bit}, 64'(me.bt));
                chk("done_latency", 64'(cyc - me.sc), 64'(me.lat));
                chk("busy_at_done", {63'd0, busy}, 64'd1);
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ram_addr"}, {55'd0, ram_addr}, 64'd0);
        chk({tag, "_ram_wdata"}, {32'd0, ram_wdata}, 64'd0);
        chk({tag, "_ram_we"}, {63'd0, ram_we}, 64'd0);
        chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
        chk({tag, "_done"}, {63'd0, done}, 64'd0);
        chk({tag, "_err_status"}, {62'd0, err_status}, 64'd0);
        chk({tag, "_err_byte"}, {55'd0, err_byte}, 64'd0);
        chk({tag, "_err_bit"}, {61'd0, err_bit}, 64'd0);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 30; i++) begin
            if (exp_q.size() == 0 && wr_q.size() == 0) break;
            @(posedge clk);
        end
        chk("drain_timeout", 64'(exp_q.size() + wr_q.size()), 64'd0);
        exp_q.delete();
        wr_q.delete();
    endtask

    // mode 0: plain op; 1: extra start pulse in cycle 3; 2: reset asserted in cycle 3.
    task automatic run_op(input logic [23:0] st_e, input logic [23:0] ca_e, input logic [8:0] b, input int mode);
        @(posedge clk); #1;
        chk("busy_idle", {63'd0, busy}, 64'd0);
        stored_ecc = st_e;
        calc_ecc   = ca_e;
        base_addr  = b;
        start      = 1'b1;
        push_exp(cyc);
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_c1", {63'd0, busy}, 64'd1);
        if (mode != 0) begin
            @(posedge clk);
            @(posedge clk); #1;
            if (mode == 1) begin
                start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
            end else begin
                rst_n = 1'b0;
                exp_q.delete();
                wr_q.delete();
                #1;
                check_reset_outputs("rst_mid");
                repeat (2) @(posedge clk);
                #1 rst_n = 1'b1;
            end
        end
        wait_drain();
    endtask

    task automatic held_start(input logic [23:0] v);
        @(posedge clk); #1;
        chk("held_busy_idle", {63'd0, busy}, 64'd0);
        stored_ecc = v;
        calc_ecc   = v;
        start      = 1'b1;
        push_exp(cyc);
        repeat (3) @(posedge clk);
        #1 push_exp(cyc);
        @(posedge clk); #1;
        start = 1'b0;
        wait_drain();
    endtask

    initial begin
        logic [31:0] saved;
        int byt;
        int bt;
        int mode;
        logic [23:0] calc;
        logic [23:0] syn;
        for (int i = 0; i < 512; i++) mem[i] = $urandom;

        #1;
        check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("post_reset");

        run_op(24'hA5A5A5, 24'hA5A5A5, 9'h033, 0);

        mem[9'h081] = 32'h12345678;
        run_op(24'h55599A, 24'h000000, 9'h080, 0);
        chk("ram_081", {32'd0, mem[9'h081]}, 64'h12345E78);

        run_op(24'h000100, 24'h000000, 9'h010, 0);
        run_op(24'h000003, 24'h000000, 9'h010, 0);

        saved = mem[9'h07B];
        run_op(24'hAAAAAA, 24'h000000, 9'h1FC, 0);
        chk("ram_07b_wrap", {32'd0, mem[9'h07B]}, {32'd0, saved ^ 32'h8000_0000});

        mem[9'h081] = 32'h12345678;
        run_op(24'h55599A, 24'h000000, 9'h080, 1);
        chk("ram_081_extra_start", {32'd0, mem[9'h081]}, 64'h12345E78);

        saved = mem[9'h081];
        run_op(24'h55599A, 24'h000000, 9'h080, 2);
        chk("ram_081_after_reset", {32'd0, mem[9'h081]}, {32'd0, saved});
        run_op(24'h55599A, 24'h000000, 9'h080, 0);
        chk("ram_081_recover", {32'd0, mem[9'h081]}, {32'd0, saved ^ 32'h0000_0800});

        held_start(24'h3C3C3C);

        for (int n = 0; n < 60; n++) begin
            mode = $urandom_range(0, 3);
            calc = 24'($urandom);
            case (mode)
                0: syn = 24'd0;
                1: begin
                    byt = $urandom_range(0, 511);
                    bt  = $urandom_range(0, 7);
                    syn = encode_err(byt, bt);
                end
                2: syn = 24'h1 << $urandom_range(0, 23);
                default: syn = 24'($urandom);
            endcase
            run_op(calc ^ syn, calc, 9'($urandom), 0);
            if (mode == 1) begin
                chk("rand_err_byte", {55'd0, err_byte}, 64'(byt));
                chk("rand_err_bit", {61'd0, err_bit}, 64'(bt));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
